uc_multiciclo: RTL and testbench

Multi-cycle control unit for the `microc` datapath, sequencing each instruction through fetch, execute and an optional I/O wait. It replaces the single-cycle `uc` decoder when the datapath runs with a program-counter enable and an external I/O port. It generates the datapath control lines (`s_inc`, `s_inm`, `we3`, `op`), the PC enable, the I/O request/ack handshake with timeout, and the halt/error status.

---
 rtl/uc_multiciclo.sv | 150 +++++++++++++++
 tb/tb_uc_multiciclo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit for the microc datapath.
// Sequences FETCH / EXEC / IOWAIT / HALT and drives the datapath controls.
module uc_multiciclo #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       z,
    input  logic [5:0] opcode,
    input  logic       io_ack,
    output logic       s_inc,
    output logic       s_inm,
    output logic       s_io,
    output logic       we3,
    output logic [2:0] op,
    output logic       pc_en,
    output logic       io_req,
    output logic       io_we,
    output logic       fin,
    output logic       err,
    output logic [1:0] estado
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        EXEC   = 2'b01,
        IOWAIT = 2'b10,
        HALT   = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    ir_q, ir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          fetch_io;
    logic          fetch_halt;

    // IN/OUT and HALT are recognised on the incoming opcode during FETCH
    assign fetch_io   = (opcode[5:2] == 4'b1010);
    assign fetch_halt = (opcode[5:1] == 5'b11111);

    // Next-state logic: instruction latch, I/O wait counter, sticky error
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            FETCH: begin
                ir_d  = opcode;
                cnt_d = '0;
                if (fetch_io) begin
                    state_d = IOWAIT;
                end else if (fetch_halt) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            IOWAIT: begin
                if (io_ack) begin
                    state_d = EXEC;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            EXEC: begin
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Control outputs decoded from state, latched instruction and zero flag
    always_comb begin
        s_inc  = 1'b1;
        s_inm  = 1'b0;
        s_io   = 1'b0;
        we3    = 1'b0;
        op     = 3'b000;
        pc_en  = 1'b0;
        io_req = 1'b0;
        io_we  = 1'b0;
        fin    = 1'b0;
        unique case (state_q)
            EXEC: begin
                pc_en = 1'b1;
                unique casez (ir_q)
                    6'b0?????: begin
                        op  = ir_q[4:2];
                        we3 = 1'b1;
                    end
                    6'b10000?: begin
                        s_inm = 1'b1;
                        we3   = 1'b1;
                    end
                    6'b10001?: s_inc = 1'b0;
                    6'b10010?: s_inc = ~z;
                    6'b10011?: s_inc = z;
                    6'b10100?: begin
                        s_io = 1'b1;
                        we3  = 1'b1;
                    end
                    default: ;
                endcase
            end
            IOWAIT: begin
                io_req = 1'b1;
                io_we  = ir_q[1];
            end
            HALT: begin
                fin = 1'b1;
            end
            default: ;
        endcase
    end

    assign estado = state_q;
    assign err    = err_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Scoreboard bench for uc_multiciclo: a per-instruction model pushes the
// expected per-cycle outputs, a negedge monitor pops and compares them.
module tb_uc_multiciclo;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       z;
    logic [5:0] opcode;
    logic       io_ack;
    logic       s_inc, s_inm, s_io, we3;
    logic [2:0] op;
    logic       pc_en, io_req, io_we, fin, err;
    logic [1:0] estado;

    uc_multiciclo #(.TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .reset  (reset),
        .z      (z),
        .opcode (opcode),
        .io_ack (io_ack),
        .s_inc  (s_inc),
        .s_inm  (s_inm),
        .s_io   (s_io),
        .we3    (we3),
        .op     (op),
        .pc_en  (pc_en),
        .io_req (io_req),
        .io_we  (io_we),
        .fin    (fin),
        .err    (err),
        .estado (estado)
    );

    always #5 clk = ~clk;

    logic [13:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    // Expected output vector:
    // {estado, s_inc, s_inm, s_io, we3, op, pc_en, io_req, io_we, fin, err}
    function automatic logic [13:0] mk(input int st, input int inc,
                                       input int inm, input int sio,
                                       input int we, input int alu,
                                       input int pce, input int req,
                                       input int iow, input int fn,
                                       input int er);
        return {2'(st), 1'(inc), 1'(inm), 1'(sio), 1'(we), 3'(alu),
                1'(pce), 1'(req), 1'(iow), 1'(fn), 1'(er)};
    endfunction

    function automatic logic [13:0] idle(input int st, input int er);
        return mk(st, 1, 0, 0, 0, 0, 0, 0, 0, (st == 3) ? 1 : 0, er);
    endfunction

    // EXEC-cycle controls, derived from the instruction class
    function automatic logic [13:0] exec_exp(input int opc, input int zv);
        int grp;
        grp = opc / 2;
        if (opc < 32)  return mk(1, 1, 0, 0, 1, (opc / 4) % 8, 1, 0, 0, 0, 0);
        if (grp == 16) return mk(1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        if (grp == 17) return mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        if (grp == 18) return mk(1, (zv == 1) ? 0 : 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        if (grp == 19) return mk(1, (zv == 1) ? 1 : 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        if (grp == 20) return mk(1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        return mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endfunction

    // One clock cycle: drive inputs just after the edge, queue the expectation
    task automatic cyc(input logic [13:0] e, input string tag,
                       input int opc, input int zv, input int ack,
                       input int rst);
        @(posedge clk);
        #1;
        opcode = 6'(opc);
        z      = 1'(zv);
        io_ack = 1'(ack);
        reset  = 1'(rst);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    function automatic int rop();
        return $urandom_range(0, 63);
    endfunction

    function automatic int rb();
        return $urandom_range(0, 1);
    endfunction

    // Halted cycles, then an optional reset cycle back to FETCH
    task automatic halt_run(input int n, input int er, input int do_rst);
        for (int i = 0; i < n; i++)
            cyc(idle(3, er), "halt", rop(), rb(), rb(), 0);
        if (do_rst != 0)
            cyc(idle(3, er), "halt_rst", rop(), rb(), rb(), 1);
    endtask

    // One instruction; ack_n = IOWAIT cycle index carrying io_ack, -1 = none.
    // Returns 1 if the unit ends up halted (HALT opcode or timeout).
    task automatic instr(input int opc, input int zv, input int ack_n,
                         output int halted, output int er);
        int grp;
        int got;
        grp    = opc / 2;
        halted = 0;
        er     = 0;
        cyc(idle(0, 0), "fetch", opc, rb(), rb(), 0);
        if (grp == 31) begin
            halted = 1;
            return;
        end
        if (grp == 20 || grp == 21) begin
            got = 0;
            for (int k = 0; k < TIMEOUT && got == 0; k++) begin
                got = (k == ack_n) ? 1 : 0;
                cyc(mk(2, 1, 0, 0, 0, 0, 0, 1, (grp == 21) ? 1 : 0, 0, 0),
                    "iowait", rop(), rb(), got, 0);
            end
            if (got == 0) begin
                halted = 1;
                er     = 1;
                return;
            end
        end
        cyc(exec_exp(opc, zv), "exec", rop(), zv, rb(), 0);
    endtask

    // IN/OUT aborted by reset on the n-th IOWAIT cycle
    task automatic io_abort(input int opc, input int n);
        cyc(idle(0, 0), "fetch", opc, rb(), rb(), 0);
        for (int k = 0; k < n; k++)
            cyc(mk(2, 1, 0, 0, 0, 0, 0, 1, ((opc / 2) == 21) ? 1 : 0, 0, 0),
                "iowait_rst", rop(), rb(), 0, (k == n - 1) ? 1 : 0);
    endtask

    // Monitor: compare every cycle the scoreboard has an entry for
    always @(negedge clk) begin
        logic [13:0] act;
        logic [13:0] e;
        string       t;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            act = {estado, s_inc, s_inm, s_io, we3, op,
                   pc_en, io_req, io_we, fin, err};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b (t=%0t)",
                         t, act, e, $time);
            end
        end
    end

    initial begin
        int h, er, opc, a, sel;
        reset  = 1'b1;
        z      = 1'b0;
        opcode = 6'd0;
        io_ack = 1'b0;
        repeat (2) @(posedge clk);

        // ALU op=001, then back to FETCH
        instr(6'b000100, 0, -1, h, er);
        // jz / jnz with both flag values
        instr(6'b100100, 1, -1, h, er);
        instr(6'b100100, 0, -1, h, er);
        instr(6'b100110, 1, -1, h, er);
        instr(6'b100110, 0, -1, h, er);
        // IN with ack on the 3rd IOWAIT cycle
        instr(6'b101000, 0, 2, h, er);
        // ack coincident with the last counter value
        instr(6'b101010, 0, TIMEOUT - 1, h, er);
        // reset in the middle of IOWAIT
        io_abort(6'b101000, 5);
        // OUT timeout, 20 halted cycles, reset
        instr(6'b101010, 0, -1, h, er);
        halt_run(20, er, 1);
        // HALT opcode, then reset
        instr(6'b111110, 0, -1, h, er);
        halt_run(4, er, 1);

        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 9);
            unique case (sel)
                0, 1: opc = $urandom_range(0, 31);
                2: opc = 32 + rb();
                3: opc = 34 + rb();
                4: opc = 36 + rb();
                5: opc = 38 + rb();
                6: opc = 40 + rb();
                7: opc = 42 + rb();
                8: opc = 2 * $urandom_range(22, 30) + rb();
                default: opc = 62 + rb();
            endcase
            a = $urandom_range(0, 11);
            if ((sel == 6 || sel == 7) && a == 0) begin
                io_abort(opc, $urandom_range(1, TIMEOUT));
            end else begin
                if (a == 1)      a = -1;
                else if (a == 2) a = TIMEOUT - 1;
                else             a = $urandom_range(0, 5);
                instr(opc, rb(), a, h, er);
                if (h != 0)
                    halt_run($urandom_range(1, 4), er, 1);
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
